// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: segment patterns in
// logical polarity (1 = segment lit, bit order gfedcba) and frame FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } frame_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of one logical-polarity segment pattern into a BCD
// digit. Blank and unknown patterns both return digit 0; the caller decides
// whether a blank is acceptable for the digit position being decoded.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       blank,
  output logic       invalid
);

  // Pattern lookup; anything outside the ten digit glyphs and all-off is invalid
  always_comb begin
    digit   = 4'd0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a two-digit multiplexed 7-segment scan bus, accepts each digit once
// it has been stable long enough, and publishes complete ones+tens frames as
// BCD and binary values with error and stale status.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [3:0] an_out,
  output logic [7:0] value_bcd,
  output logic [6:0] value_bin,
  output logic       valid,
  output logic       changed,
  output logic       err,
  output logic       stale
);

  localparam int STAB_W  = $clog2(STABLE_CYCLES);
  localparam int STALE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT_CYCLES);

  // Saturating increment for the stale timer
  function automatic logic [STALE_W-1:0] stale_sat_inc(input logic [STALE_W-1:0] x);
    return (x == STALE_MAX) ? x : x + 1'b1;
  endfunction

  // tens*10 + ones using shifts and adds only
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, ones};
  endfunction

  logic [6:0]   seg_q;
  logic [3:0]   an_q;
  logic [10:0]  sample_prev;
  logic [STAB_W-1:0]  stab_cnt;
  logic [STALE_W-1:0] stale_cnt;
  logic         armed;
  logic         same;
  logic         selecting;
  logic         capture;
  logic         cap_ones;
  logic         cap_tens;

  logic [3:0]   dec_digit;
  logic         dec_blank;
  logic         dec_invalid;

  frame_state_t state, state_n;
  logic [3:0]   ones_digit, ones_n;
  logic [3:0]   tens_digit, tens_n;
  logic         err_ones, err_ones_n;
  logic         err_tens, err_tens_n;
  logic         got_ones, got_ones_n;
  logic         got_tens, got_tens_n;
  logic         publish;

  seg7_pattern_decode u_decode (
    .pattern (~seg_q),
    .digit   (dec_digit),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  assign same      = ({an_q, seg_q} == sample_prev);
  assign selecting = (an_q[3:2] == 2'b11) && (an_q[1] ^ an_q[0]);
  assign capture   = selecting && same && armed && (stab_cnt == STAB_LAST);
  assign cap_ones  = capture && !an_q[0];
  assign cap_tens  = capture && !an_q[1];
  assign stale     = (stale_cnt == STALE_MAX);

  // Input register stage: everything downstream works on seg_q/an_q
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg;
      an_q  <= an_out;
    end
  end

  // Stability counter with one-shot capture; armed re-opens only on a bus change
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_prev <= {4'hF, 7'h7F};
      stab_cnt    <= '0;
      armed       <= 1'b1;
    end else begin
      sample_prev <= {an_q, seg_q};
      if (selecting && same)
        stab_cnt <= (stab_cnt == STAB_LAST) ? stab_cnt : stab_cnt + 1'b1;
      else
        stab_cnt <= '0;
      if (!same)
        armed <= 1'b1;
      else if (capture)
        armed <= 1'b0;
    end
  end

  // Stale timer: restarts on every capture, saturates at the timeout
  always_ff @(posedge clk) begin
    if (rst)
      stale_cnt <= '0;
    else if (capture)
      stale_cnt <= '0;
    else
      stale_cnt <= stale_sat_inc(stale_cnt);
  end

  // Frame next-state: PUBLISH clears the flags, but a capture in that same
  // cycle still lands so it starts the next frame
  always_comb begin
    state_n    = state;
    ones_n     = ones_digit;
    tens_n     = tens_digit;
    err_ones_n = err_ones;
    err_tens_n = err_tens;
    got_ones_n = got_ones;
    got_tens_n = got_tens;
    publish    = 1'b0;
    if (state == PUBLISH) begin
      got_ones_n = 1'b0;
      got_tens_n = 1'b0;
      state_n    = COLLECT;
    end
    if (cap_ones) begin
      ones_n     = dec_digit;
      err_ones_n = dec_invalid | dec_blank;
      got_ones_n = 1'b1;
    end
    if (cap_tens) begin
      tens_n     = dec_digit;
      err_tens_n = dec_invalid;
      got_tens_n = 1'b1;
    end
    if ((state == COLLECT) && got_ones_n && got_tens_n) begin
      state_n = PUBLISH;
      publish = 1'b1;
    end
  end

  // Frame state and collection flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      got_ones <= 1'b0;
      got_tens <= 1'b0;
      err_ones <= 1'b0;
      err_tens <= 1'b0;
    end else begin
      state    <= state_n;
      got_ones <= got_ones_n;
      got_tens <= got_tens_n;
      err_ones <= err_ones_n;
      err_tens <= err_tens_n;
    end
  end

  // Digit slots are pure data and only meaningful while their flag is set
  always_ff @(posedge clk) begin
    ones_digit <= ones_n;
    tens_digit <= tens_n;
  end

  // Published outputs load together so valid and the value appear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      value_bcd <= 8'h00;
      value_bin <= 7'd0;
      valid     <= 1'b0;
      changed   <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid   <= publish;
      changed <= publish && ({tens_n, ones_n} != value_bcd);
      if (publish) begin
        value_bcd <= {tens_n, ones_n};
        value_bin <= bcd_to_bin(tens_n, ones_n);
        err       <= err_ones_n | err_tens_n;
      end
    end
  end

endmodule
